// File: rtl/spi_pkt_tx.sv
// spi_pkt_tx: SPI slave (mode 0) transmitter for one 64-bit packet at a time.
// It pulls bytes from the upstream packet shift register with spi_en/shift_en and
// serialises them MSB-first on spi_miso. SCLK and CS_n are oversampled in the
// clk domain, so clk must run at 16x SCLK or faster.
// Optional feature macro: SPI_TX_ABORT_CNT_EN adds the saturating abort_cnt output.
module spi_pkt_tx #(
    parameter int PKT_BYTES = 8,
    parameter int SYNC_STG  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_rdy,
    input  logic [7:0] byte_in,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    output logic       spi_en,
    output logic       shift_en,
    output logic       spi_miso,
    output logic       miso_oe,
    output logic       busy,
    output logic       pkt_done
`ifdef SPI_TX_ABORT_CNT_EN
   ,output logic [7:0] abort_cnt
`endif
);

    localparam int BCW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(PKT_BYTES - 1);

    typedef enum logic [2:0] {IDLE, REQ, CAPT, ARMED, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [SYNC_STG-1:0] sclk_sync, cs_sync;
    logic                sclk_d, cs_d;
    logic                sclk_s, cs_s, cs_act;
    logic                sclk_rise, sclk_fall, cs_fall;
    logic [7:0]          tx_sr, nxt_byte;
    logic [3:0]          bit_cnt;
    logic [BCW-1:0]      byte_cnt;
    logic [1:0]          pf_pipe;   // [0]: prefetch request cycle, [1]: prefetch capture cycle
    logic                pf_start, abort;

    assign sclk_s    = sclk_sync[SYNC_STG-1];
    assign cs_s      = cs_sync[SYNC_STG-1];
    assign cs_act    = ~cs_s;
    assign sclk_rise = sclk_s & ~sclk_d & cs_act;
    assign sclk_fall = ~sclk_s & sclk_d & cs_act;
    assign cs_fall   = ~cs_s & cs_d;

    // Synchronise SCLK/CS_n into clk and keep one delayed copy for edge detection.
    // CS resets to the inactive (high) level so the pad stays disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync[0] <= spi_sclk;
            cs_sync[0]   <= spi_cs_n;
            for (int i = 1; i < SYNC_STG; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
            end
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; prefetches of later bytes run beside SHIFT via pf_pipe.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        pf_start  = 1'b0;
        case (state)
            IDLE:  if (pkt_rdy) state_nxt = REQ;
            REQ:   state_nxt = CAPT;
            CAPT:  state_nxt = (byte_cnt == '0) ? ARMED : SHIFT;
            ARMED: if (cs_fall) state_nxt = SHIFT;
            SHIFT: begin
                if (cs_s) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (sclk_rise && bit_cnt == 4'd7) begin
                    if (byte_cnt == LAST_BYTE) state_nxt = DONE;
                    else                       pf_start  = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte capture, bit serialisation and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sr    <= '0;
            nxt_byte <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            pf_pipe  <= '0;
        end else begin
            pf_pipe <= abort ? 2'b00 : {pf_pipe[0], pf_start};
            if (pf_pipe[1] && !abort) nxt_byte <= byte_in;
            case (state)
                IDLE: if (pkt_rdy) begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
                CAPT: begin
                    nxt_byte <= byte_in;
                    if (byte_cnt == '0) tx_sr <= byte_in;
                end
                ARMED: if (cs_fall) bit_cnt <= '0;
                SHIFT: begin
                    if (abort) begin
                        tx_sr    <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end else if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (sclk_fall) begin
                        if (bit_cnt == 4'd8) begin
                            tx_sr    <= nxt_byte;
                            bit_cnt  <= '0;
                            byte_cnt <= byte_cnt + BCW'(1);
                        end else begin
                            tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_TX_ABORT_CNT_EN
    // Count mid-packet CS aborts, saturating at 255.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            abort_cnt <= '0;
        else if (abort && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
    end
`endif

    assign spi_en   = (state == REQ)  | pf_pipe[0];
    assign shift_en = (state == CAPT) | pf_pipe[1];
    assign spi_miso = ((state == ARMED) || (state == SHIFT)) & tx_sr[7];
    assign miso_oe  = cs_act;
    assign busy     = (state != IDLE);
    assign pkt_done = (state == DONE);

endmodule

// File: tb/tb_spi_pkt_tx.sv
// tb_spi_pkt_tx: directed bench for spi_pkt_tx. Models the upstream packet
// register and an SPI mode-0 master at clk/16; received bytes are scored
// against a queue of bytes pushed when each packet is loaded.
module tb_spi_pkt_tx;
    localparam int PKT_BYTES = 8;
    localparam int SYNC_STG  = 2;

    logic       clk = 1'b0, rst = 1'b0, pkt_rdy = 1'b0;
    logic       spi_sclk = 1'b0, spi_cs_n = 1'b1;
    logic [7:0] byte_in;
    logic       spi_en, shift_en, spi_miso, miso_oe, busy, pkt_done;
`ifdef SPI_TX_ABORT_CNT_EN
    logic [7:0] abort_cnt;
`endif

    spi_pkt_tx #(.PKT_BYTES(PKT_BYTES), .SYNC_STG(SYNC_STG)) dut (
        .clk(clk), .rst(rst), .pkt_rdy(pkt_rdy), .byte_in(byte_in),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_en(spi_en),
        .shift_en(shift_en), .spi_miso(spi_miso), .miso_oe(miso_oe),
        .busy(busy), .pkt_done(pkt_done)
`ifdef SPI_TX_ABORT_CNT_EN
       ,.abort_cnt(abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    // packet register model: presents pkt_mem[idx], advances on shift_en
    logic [7:0] pkt_mem [PKT_BYTES];
    int idx = 0;
    int en_cnt = 0, sh_cnt = 0, done_cnt = 0, ovl_cnt = 0;
    assign byte_in = (idx < PKT_BYTES) ? pkt_mem[idx] : 8'h00;

    always @(posedge clk) begin
        if (pkt_rdy && !busy) idx <= 0;
        else if (shift_en)    idx <= idx + 1;
        if (spi_en)              en_cnt   <= en_cnt + 1;
        if (shift_en)            sh_cnt   <= sh_cnt + 1;
        if (pkt_done)            done_cnt <= done_cnt + 1;
        if (spi_en && shift_en)  ovl_cnt  <= ovl_cnt + 1;
    end

    logic [7:0]  exp_q [$];
    logic [7:0]  rx_sr = '0;
    logic [63:0] rx64 = '0;
    int rx_n = 0;
    int n_tests = 0, n_fail = 0;
    int e0, s0, d0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        e0 = en_cnt; s0 = sh_cnt; d0 = done_cnt;
    endtask

    task automatic pulse_rdy();
        @(negedge clk); pkt_rdy = 1'b1;
        @(negedge clk); pkt_rdy = 1'b0;
    endtask

    task automatic load_pkt(input logic [63:0] p);
        for (int i = 0; i < PKT_BYTES; i++) begin
            pkt_mem[i] = p[63-8*i -: 8];
            exp_q.push_back(p[63-8*i -: 8]);
        end
        pulse_rdy();
    endtask

    // master samples MISO on its own SCLK rise (mode 0)
    task automatic rise_bit();
        logic [7:0] e;
        spi_sclk = 1'b1;
        rx_sr = {rx_sr[6:0], spi_miso};
        rx64  = {rx64[62:0], spi_miso};
        rx_n++;
        if (rx_n == 8) begin
            rx_n = 0;
            n_tests++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_empty: observed byte %0h expected none queued", rx_sr);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_byte", rx_sr, e);
            end
        end
    endtask

    task automatic xfer(input int n);
        for (int i = 0; i < n; i++) begin
            wait_clk(8); rise_bit();
            wait_clk(8); spi_sclk = 1'b0;
        end
    endtask

    task automatic full_pkt(input logic [63:0] p);
        load_pkt(p);
        wait_clk(6);
        spi_cs_n = 1'b0;
        xfer(64);
        wait_clk(8);
        spi_cs_n = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < PKT_BYTES; i++) pkt_mem[i] = 8'h00;

        // reset state
        wait_clk(3);
        chk("rst_outs", {spi_en, shift_en, spi_miso, miso_oe, busy, pkt_done}, 6'b0);
        rst = 1'b1;
        wait_clk(2);
        chk("idle_outs", {spi_en, shift_en, spi_miso, miso_oe, busy, pkt_done}, 6'b0);
`ifdef SPI_TX_ABORT_CNT_EN
        chk("rst_abort_cnt", abort_cnt, 8'd0);
`endif

        // SCLK activity outside a packet is ignored
        spi_cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 3; i++) begin
            wait_clk(8); spi_sclk = 1'b1;
            chk("idle_miso", spi_miso, 1'b0);
            wait_clk(8); spi_sclk = 1'b0;
        end
        chk("idle_busy", busy, 1'b0);
        chk("idle_no_en", en_cnt, 0);
        spi_cs_n = 1'b1;
        wait_clk(4);

        // 1: single packet
        snap();
        load_pkt(64'h0123_4567_89AB_CDEF);
        wait_clk(6);
        chk("t1_armed_busy", busy, 1'b1);
        chk("t1_armed_miso", spi_miso, 1'b0);
        spi_cs_n = 1'b0;
        xfer(64);
        wait_clk(8);
        chk("t1_oe", miso_oe, 1'b1);
        spi_cs_n = 1'b1;
        wait_clk(6);
        chk("t1_rx", rx64, 64'h0123_4567_89AB_CDEF);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_en", en_cnt - e0, 8);
        chk("t1_sh", sh_cnt - s0, 8);
        chk("t1_busy", busy, 1'b0);

        // 2: back-to-back, next pkt_rdy one cycle after pkt_done
        snap();
        load_pkt(64'hA5C3_0F1E_2D3C_4B5A);
        wait_clk(6);
        spi_cs_n = 1'b0;
        xfer(63);
        wait_clk(8);
        rise_bit();
        k = 0;
        while (done_cnt == d0 && k < 20) begin wait_clk(1); k++; end
        chk("t2_done_wait", done_cnt - d0, 1);
        load_pkt(64'h8000_0000_0000_0001);
        wait_clk(6);
        spi_sclk = 1'b0;
        wait_clk(8);
        spi_cs_n = 1'b1;
        wait_clk(8);
        spi_cs_n = 1'b0;
        xfer(64);
        wait_clk(8);
        spi_cs_n = 1'b1;
        wait_clk(6);
        chk("t2_rx", rx64, 64'h8000_0000_0000_0001);
        chk("t2_done", done_cnt - d0, 2);
        chk("t2_en", en_cnt - e0, 16);
        chk("t2_sh", sh_cnt - s0, 16);

        // 3: CS abort after 20 rising edges
        snap();
        load_pkt(64'hFEDC_BA98_7654_3210);
        wait_clk(6);
        spi_cs_n = 1'b0;
        xfer(20);
        wait_clk(8);
        chk("t3_busy_pre", busy, 1'b1);
        spi_cs_n = 1'b1;
        wait_clk(1 + SYNC_STG);
        chk("t3_idle", busy, 1'b0);
        chk("t3_miso", spi_miso, 1'b0);
        wait_clk(10);
        chk("t3_no_done", done_cnt - d0, 0);
        chk("t3_en", en_cnt - e0, 3);
`ifdef SPI_TX_ABORT_CNT_EN
        chk("t3_abort_cnt", abort_cnt, 8'd1);
`endif
        exp_q.delete();
        rx_n = 0;

        // 4: pkt_rdy while busy is ignored
        snap();
        load_pkt(64'h1122_3344_5566_7788);
        wait_clk(2);
        pulse_rdy();
        wait_clk(4);
        spi_cs_n = 1'b0;
        xfer(10);
        pulse_rdy();
        xfer(54);
        wait_clk(8);
        spi_cs_n = 1'b1;
        wait_clk(6);
        chk("t4_rx", rx64, 64'h1122_3344_5566_7788);
        chk("t4_done", done_cnt - d0, 1);
        chk("t4_en", en_cnt - e0, 8);
        chk("t4_sh", sh_cnt - s0, 8);

        // 5: async reset mid-byte, then a clean packet
        load_pkt(64'hDEAD_BEEF_CAFE_F00D);
        wait_clk(6);
        spi_cs_n = 1'b0;
        xfer(12);
        wait_clk(3);
        #2 rst = 1'b0;
        #1;
        chk("t5_async", {spi_miso, busy, spi_en, shift_en, pkt_done, miso_oe}, 6'b0);
        wait_clk(2);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        exp_q.delete();
        rx_n = 0;
        rst = 1'b1;
        wait_clk(4);
`ifdef SPI_TX_ABORT_CNT_EN
        chk("t5_abort_cnt_rst", abort_cnt, 8'd0);
`endif
        snap();
        full_pkt(64'h0F1E_2D3C_4B5A_6978);
        chk("t5_rx", rx64, 64'h0F1E_2D3C_4B5A_6978);
        chk("t5_done", done_cnt - d0, 1);
        chk("t5_en", en_cnt - e0, 8);

`ifdef SPI_TX_ABORT_CNT_EN
        // 6: abort counter saturation
        snap();
        for (int i = 0; i < 300; i++) begin
            pulse_rdy();
            wait_clk(4);
            spi_cs_n = 1'b0;
            wait_clk(5);
            spi_cs_n = 1'b1;
            wait_clk(5);
            if (i == 254) chk("t6_cnt_255", abort_cnt, 8'd255);
        end
        chk("t6_sat", abort_cnt, 8'd255);
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_idle", busy, 1'b0);
`endif

        chk("no_en_sh_overlap", ovl_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
